// File: rtl/mult_pkg.sv
// Shared definitions for the iterative arithmetic blocks.
// State encoding and counter sizing helpers.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier, WIDTH cycles per product.
// Same start/ready handshake as the sequential divider.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               ready
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_t           state;
  logic             neg;
  logic [PW-1:0]    mcand_reg;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier_reg;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    prod_next;

  // Magnitudes are unsigned, so -2^(W-1) stays representable.
  always_comb begin
    mag_a = (sign & multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    mag_b = (sign & multiplier[WIDTH-1]) ? -multiplier : multiplier;
    acc_next = acc + (mplier_reg[0] ? mcand_reg : '0);
    prod_next = neg ? -acc_next : acc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      neg        <= 1'b0;
      mcand_reg  <= '0;
      acc        <= '0;
      mplier_reg <= '0;
      count      <= '0;
      product    <= '0;
      busy       <= 1'b0;
      ready      <= 1'b0;
    end else if (start) begin
      neg        <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
      mplier_reg <= mag_b;
      acc        <= '0;
      count      <= CNT_W'(WIDTH);
      state      <= S_RUN;
      busy       <= 1'b1;
      ready      <= 1'b0;
    end else begin
      unique case (state)
        S_RUN: begin
          acc        <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count      <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            product <= prod_next;
            state   <= S_DONE;
            busy    <= 1'b0;
            ready   <= 1'b1;
          end
        end
        S_DONE: begin
          ready <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=13).
// Reference products computed with plain integer arithmetic.
module tb_seq_multiplier;

  localparam int W  = 13;
  localparam int PW = 2 * W;

  logic          clk;
  logic          reset;
  logic          start;
  logic          sign;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic [PW-1:0] product;
  logic          busy;
  logic          ready;

  int checks;
  int failures;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sign         (sign),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_mul(input bit s,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint x;
    longint y;
    longint p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[PW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, wait for ready; reports edges from start edge to ready.
  task automatic run_op(input bit s, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat,
                        output int bad);
    logic [PW-1:0] held;
    held = product;
    start = 1'b1;
    sign = s;
    multiplicand = a;
    multiplier = b;
    tick();
    start = 1'b0;
    multiplicand = $urandom;
    multiplier = $urandom;
    sign = $urandom;
    lat = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy || product !== held) bad++;
      tick();
      lat++;
      if (ready) break;
    end
  endtask

  task automatic op_check(input string tag, input bit s,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    int bad;
    run_op(s, a, b, lat, bad);
    check({tag, "_lat"}, 64'(lat), 64'(W));
    check({tag, "_run"}, 64'(bad), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_prod"}, 64'(product), 64'(ref_mul(s, a, b)));
  endtask

  initial begin
    int lat;
    int bad;
    int pulses;
    logic [PW-1:0] last;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit rs;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    sign = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    tick();
    tick();
    check("rst_prod", 64'(product), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    reset = 1'b0;
    tick();

    op_check("umax", 1'b0, 13'h1FFF, 13'h1FFF);
    check("umax_const", 64'(product), 64'h3FFC001);
    tick();
    check("umax_rdy_drop", 64'(ready), 64'd0);

    op_check("smix", 1'b1, 13'h1FF9, 13'd3);
    check("smix_const", 64'(product), 64'h3FFFFEB);
    op_check("umix", 1'b0, 13'h1FF9, 13'd3);
    check("umix_const", 64'(product), 64'h0005FEB);
    op_check("smin", 1'b1, 13'h1000, 13'h1000);
    check("smin_const", 64'(product), 64'h1000000);
    op_check("smin1", 1'b1, 13'h1000, 13'd1);
    check("smin1_const", 64'(product), 64'h3FFF000);

    op_check("zero", 1'b1, 13'd0, 13'h0ABC);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ready || product !== '0) bad++;
    end
    check("zero_hold", 64'(bad), 64'd0);

    // Restart mid-run: first op must never complete.
    start = 1'b1;
    sign = 1'b0;
    multiplicand = 13'd5;
    multiplier = 13'd5;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ready) pulses++;
    end
    op_check("restart", 1'b0, 13'd12, 13'd10);
    check("restart_120", 64'(product), 64'd120);
    for (int i = 0; i < 25; i++) begin
      tick();
      if (ready) pulses++;
    end
    check("restart_pulses", 64'(pulses), 64'd0);

    // Back-to-back: second start lands in the ready cycle.
    op_check("b2b_a", 1'b1, 13'h0123, 13'h1F00);
    op_check("b2b_b", 1'b0, 13'h0F0F, 13'h0777);

    // Start held high keeps restarting.
    start = 1'b1;
    sign = 1'b1;
    multiplicand = 13'h1234;
    multiplier = 13'h0567;
    last = product;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ready || !busy || product !== last) bad++;
    end
    check("hold_start", 64'(bad), 64'd0);
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (ready) break;
    end
    check("hold_lat", 64'(lat), 64'(W));
    check("hold_prod", 64'(product), 64'(ref_mul(1'b1, 13'h1234, 13'h0567)));

    // Async reset between edges mid-run.
    start = 1'b1;
    sign = 1'b0;
    multiplicand = 13'h0FFF;
    multiplier = 13'h0FFF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    #3 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(ready), 64'd0);
    check("arst_prod", 64'(product), 64'd0);
    #2 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ready || busy) bad++;
    end
    check("arst_quiet", 64'(bad), 64'd0);

    for (int n = 0; n < 20; n++) begin
      rs = 1'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      if (n == 0) ra = '0;
      if (n == 1) rb = 13'h1000;
      op_check("rand", rs, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
